// File: rtl/ysyx_22040386_arb_pkg.sv
// Shared types and defaults for the IF/MEM memory arbiter.
package ysyx_22040386_arb_pkg;

   localparam int DEF_AW = 64;
   localparam int DEF_DW = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_MEM
   } arb_owner_t;

   // Streak counter must be able to hold the value MAX_MEM_STREAK itself.
   function automatic int streak_width(input int max_streak);
      return $clog2(max_streak + 1);
   endfunction

endpackage

// File: rtl/ysyx_22040386_arb_sel.sv
// Winner selection: MEM first, but IF is forced through once MEM has won
// MAX_MEM_STREAK times in a row while IF was waiting.
module ysyx_22040386_arb_sel
   import ysyx_22040386_arb_pkg::*;
#(
   parameter int MAX_MEM_STREAK = 4,
   parameter int SW             = streak_width(MAX_MEM_STREAK)
) (
   input  logic          if_req,
   input  logic          mem_req,
   input  logic [SW-1:0] streak,
   output arb_owner_t    owner,
   output logic [SW-1:0] streak_nxt
);

   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

   always_comb begin
      owner      = OWN_NONE;
      streak_nxt = streak;
      if (mem_req && (streak < STREAK_MAX)) begin
         owner      = OWN_MEM;
         streak_nxt = if_req ? streak + SW'(1) : '0;
      end else if (if_req) begin
         owner      = OWN_IF;
         streak_nxt = '0;
      end else if (mem_req) begin
         owner      = OWN_MEM;
         streak_nxt = '0;
      end
   end

endmodule

// File: rtl/ysyx_22040386_mem_arbiter.sv
// Two-requester (IF read-only, MEM read/write) to single bus arbiter, one
// transaction outstanding, registered bus payload.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate; winner's payload is registered onto the bus
// ST_ISSUE | bus_valid held with stable payload until bus_ready
// ST_WAIT  | waiting for bus_rvalid; response routed to owner next cycle
module ysyx_22040386_mem_arbiter
   import ysyx_22040386_arb_pkg::*;
#(
   parameter int AW             = DEF_AW,
   parameter int DW             = DEF_DW,
   parameter int MAX_MEM_STREAK = 4
) (
   input  logic            i_ARB_clk,
   input  logic            i_ARB_rst_n,
   input  logic            i_ARB_if_req,
   input  logic [AW-1:0]   i_ARB_if_addr,
   output logic            o_ARB_if_gnt,
   output logic            o_ARB_if_rvalid,
   output logic [DW-1:0]   o_ARB_if_rdata,
   input  logic            i_ARB_mem_req,
   input  logic            i_ARB_mem_we,
   input  logic [AW-1:0]   i_ARB_mem_addr,
   input  logic [DW-1:0]   i_ARB_mem_wdata,
   input  logic [DW/8-1:0] i_ARB_mem_wmask,
   output logic            o_ARB_mem_gnt,
   output logic            o_ARB_mem_rvalid,
   output logic [DW-1:0]   o_ARB_mem_rdata,
   input  logic            i_ARB_flush,
   output logic            o_ARB_bus_valid,
   output logic            o_ARB_bus_we,
   output logic [AW-1:0]   o_ARB_bus_addr,
   output logic [DW-1:0]   o_ARB_bus_wdata,
   output logic [DW/8-1:0] o_ARB_bus_wmask,
   input  logic            i_ARB_bus_ready,
   input  logic            i_ARB_bus_rvalid,
   input  logic [DW-1:0]   i_ARB_bus_rdata
);

   localparam int SW = streak_width(MAX_MEM_STREAK);

   arb_state_t    state, state_nxt;
   arb_owner_t    owner, sel_owner;
   logic [SW-1:0] streak, sel_streak;
   logic          drop;
   logic          grant_now, bus_hs, resp_now, flush_hit, if_drop_resp;

   ysyx_22040386_arb_sel #(
      .MAX_MEM_STREAK(MAX_MEM_STREAK),
      .SW            (SW)
   ) u_sel (
      .if_req    (i_ARB_if_req),
      .mem_req   (i_ARB_mem_req),
      .streak    (streak),
      .owner     (sel_owner),
      .streak_nxt(sel_streak)
   );

   assign grant_now    = (state == ST_IDLE) && (sel_owner != OWN_NONE);
   assign bus_hs       = o_ARB_bus_valid && i_ARB_bus_ready;
   assign resp_now     = (state == ST_WAIT) && i_ARB_bus_rvalid;
   assign flush_hit    = i_ARB_flush && (owner == OWN_IF) && (state != ST_IDLE);
   // A flush in the same cycle as the response still discards it.
   assign if_drop_resp = drop || flush_hit;

   assign o_ARB_if_gnt  = bus_hs && (owner == OWN_IF);
   assign o_ARB_mem_gnt = bus_hs && (owner == OWN_MEM);

   always_ff @(posedge i_ARB_clk or negedge i_ARB_rst_n) begin
      if (!i_ARB_rst_n) state <= ST_IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (grant_now)        state_nxt = ST_ISSUE;
         ST_ISSUE: if (i_ARB_bus_ready)  state_nxt = ST_WAIT;
         ST_WAIT:  if (i_ARB_bus_rvalid) state_nxt = ST_IDLE;
         default:                        state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_ARB_clk or negedge i_ARB_rst_n) begin
      if (!i_ARB_rst_n) begin
         owner            <= OWN_NONE;
         streak           <= '0;
         drop             <= 1'b0;
         o_ARB_bus_valid  <= 1'b0;
         o_ARB_bus_we     <= 1'b0;
         o_ARB_bus_addr   <= '0;
         o_ARB_bus_wdata  <= '0;
         o_ARB_bus_wmask  <= '0;
         o_ARB_if_rvalid  <= 1'b0;
         o_ARB_if_rdata   <= '0;
         o_ARB_mem_rvalid <= 1'b0;
         o_ARB_mem_rdata  <= '0;
      end else begin
         o_ARB_if_rvalid  <= 1'b0;
         o_ARB_mem_rvalid <= 1'b0;
         if (grant_now) begin
            owner           <= sel_owner;
            streak          <= sel_streak;
            o_ARB_bus_valid <= 1'b1;
            if (sel_owner == OWN_MEM) begin
               o_ARB_bus_we    <= i_ARB_mem_we;
               o_ARB_bus_addr  <= i_ARB_mem_addr;
               o_ARB_bus_wdata <= i_ARB_mem_wdata;
               o_ARB_bus_wmask <= i_ARB_mem_wmask;
            end else begin
               o_ARB_bus_we    <= 1'b0;
               o_ARB_bus_addr  <= i_ARB_if_addr;
               o_ARB_bus_wdata <= '0;
               o_ARB_bus_wmask <= '0;
            end
         end
         if (bus_hs)    o_ARB_bus_valid <= 1'b0;
         if (flush_hit) drop <= 1'b1;
         if (resp_now) begin
            drop  <= 1'b0;
            owner <= OWN_NONE;
            if (owner == OWN_MEM) begin
               o_ARB_mem_rvalid <= 1'b1;
               o_ARB_mem_rdata  <= o_ARB_bus_we ? '0 : i_ARB_bus_rdata;
            end else if (!if_drop_resp) begin
               o_ARB_if_rvalid <= 1'b1;
               o_ARB_if_rdata  <= i_ARB_bus_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040386_mem_arbiter.sv
// Scoreboard bench for the IF/MEM arbiter: stimulus pushes expected grants and
// responses, a negedge monitor pops and compares, a bus model answers requests.
module tb_ysyx_22040386_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_gnt, if_rvalid;
   logic [63:0] if_addr, if_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;
   logic        flush;
   logic        bus_valid, bus_we, bus_ready, bus_rvalid;
   logic [63:0] bus_addr, bus_wdata, bus_rdata;
   logic [7:0]  bus_wmask;

   always #5 clk = ~clk;

   ysyx_22040386_mem_arbiter #(.AW(64), .DW(64), .MAX_MEM_STREAK(4)) dut (
      .i_ARB_clk       (clk),
      .i_ARB_rst_n     (rst_n),
      .i_ARB_if_req    (if_req),
      .i_ARB_if_addr   (if_addr),
      .o_ARB_if_gnt    (if_gnt),
      .o_ARB_if_rvalid (if_rvalid),
      .o_ARB_if_rdata  (if_rdata),
      .i_ARB_mem_req   (mem_req),
      .i_ARB_mem_we    (mem_we),
      .i_ARB_mem_addr  (mem_addr),
      .i_ARB_mem_wdata (mem_wdata),
      .i_ARB_mem_wmask (mem_wmask),
      .o_ARB_mem_gnt   (mem_gnt),
      .o_ARB_mem_rvalid(mem_rvalid),
      .o_ARB_mem_rdata (mem_rdata),
      .i_ARB_flush     (flush),
      .o_ARB_bus_valid (bus_valid),
      .o_ARB_bus_we    (bus_we),
      .o_ARB_bus_addr  (bus_addr),
      .o_ARB_bus_wdata (bus_wdata),
      .o_ARB_bus_wmask (bus_wmask),
      .i_ARB_bus_ready (bus_ready),
      .i_ARB_bus_rvalid(bus_rvalid),
      .i_ARB_bus_rdata (bus_rdata)
   );

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   logic [63:0] exp_if_q[$];
   logic [63:0] exp_mem_q[$];
   logic [1:0]  exp_gnt_q[$];
   int if_gnt_cyc, mem_gnt_cyc, if_rv_cyc, if_rv_cnt;

   int bus_stall, bus_rlat, stall_left, resp_cnt;
   bit in_txn;
   logic [63:0] resp_data, cap_addr, cap_wdata, hs_addr, hs_wdata;
   logic [8:0]  cap_ctl, hs_ctl;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] bus_data(input logic [63:0] a);
      return (a == 64'h8000_0000) ? 64'h13 : (a ^ 64'h1234_5678_9ABC_DEF0);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every grant and response is matched against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (if_gnt || mem_gnt) begin
            if (exp_gnt_q.size() == 0) check("gnt_unexpected", {62'd0, mem_gnt, if_gnt}, 64'd0);
            else check("gnt_order", {62'd0, mem_gnt, if_gnt}, {62'd0, exp_gnt_q.pop_front()});
            if (if_gnt)  if_gnt_cyc  <= cyc;
            if (mem_gnt) mem_gnt_cyc <= cyc;
         end
         if (if_rvalid) begin
            if (exp_if_q.size() == 0) check("if_rvalid_unexpected", {63'd0, if_rvalid}, 64'd0);
            else check("if_rdata", if_rdata, exp_if_q.pop_front());
            if_rv_cyc <= cyc;
            if_rv_cnt <= if_rv_cnt + 1;
         end
         if (mem_rvalid) begin
            if (exp_mem_q.size() == 0) check("mem_rvalid_unexpected", {63'd0, mem_rvalid}, 64'd0);
            else check("mem_rdata", mem_rdata, exp_mem_q.pop_front());
         end
      end
   end

   // Bus model: optional ready stall, response bus_rlat cycles after handshake.
   initial begin
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      resp_cnt = 0; stall_left = 0; in_txn = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus_rvalid = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               bus_rvalid = 1'b1;
               bus_rdata  = resp_data;
            end
         end
         bus_ready = 1'b0;
         if (bus_valid) begin
            if (!in_txn) begin
               in_txn     = 1'b1;
               stall_left = bus_stall;
               cap_addr   = bus_addr;
               cap_wdata  = bus_wdata;
               cap_ctl    = {bus_we, bus_wmask};
            end else begin
               check("stall_addr_stable", bus_addr, cap_addr);
               check("stall_wdata_stable", bus_wdata, cap_wdata);
               check("stall_ctl_stable", {55'd0, bus_we, bus_wmask}, {55'd0, cap_ctl});
            end
            if (stall_left > 0) stall_left--;
            else begin
               bus_ready = 1'b1;
               in_txn    = 1'b0;
               resp_cnt  = bus_rlat;
               resp_data = bus_data(bus_addr);
               hs_addr   = bus_addr;
               hs_wdata  = bus_wdata;
               hs_ctl    = {bus_we, bus_wmask};
            end
         end
      end
   end

   task automatic if_fetch(input logic [63:0] addr, input logic [63:0] exp, input bit expect_resp);
      bit seen = 1'b0;
      if (expect_resp) exp_if_q.push_back(exp);
      if_req = 1'b1; if_addr = addr;
      for (int k = 0; k < 300 && !seen; k++) begin
         @(negedge clk);
         seen = if_gnt;
      end
      check("if_gnt_seen", {63'd0, seen}, 64'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic mem_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [7:0] wmask, input logic [63:0] exp, input bit expect_resp);
      bit seen = 1'b0;
      if (expect_resp) exp_mem_q.push_back(exp);
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_wmask = wmask;
      for (int k = 0; k < 300 && !seen; k++) begin
         @(negedge clk);
         seen = mem_gnt;
      end
      check("mem_gnt_seen", {63'd0, seen}, 64'd1);
      @(posedge clk); #1;
      mem_req = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (exp_if_q.size() == 0 && exp_mem_q.size() == 0 && exp_gnt_q.size() == 0) break;
      end
      check({tag, "_drain"}, 64'(exp_if_q.size() + exp_mem_q.size() + exp_gnt_q.size()), 64'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctl"}, {58'd0, if_gnt, if_rvalid, mem_gnt, mem_rvalid, bus_valid, bus_we}, 64'd0);
      check({tag, "_if_rdata"}, if_rdata, 64'd0);
      check({tag, "_mem_rdata"}, mem_rdata, 64'd0);
      check({tag, "_bus_addr"}, bus_addr, 64'd0);
      check({tag, "_bus_wdata"}, bus_wdata, 64'd0);
      check({tag, "_bus_wmask"}, {56'd0, bus_wmask}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      if_gnt_cyc = 0; mem_gnt_cyc = 0; if_rv_cyc = 0; if_rv_cnt = 0;
      bus_stall = 0; bus_rlat = 1;
      rst_n = 1'b0; flush = 1'b0;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: lone IF fetch, latency and read data
      exp_gnt_q.push_back(2'd1);
      t0 = cyc;
      if_fetch(64'h8000_0000, 64'h13, 1'b1);
      for (int k = 0; k < 20 && if_rv_cnt == 0; k++) @(negedge clk);
      check("t1_gnt_latency", 64'(if_gnt_cyc - t0), 64'd1);
      check("t1_rvalid_latency", 64'(if_rv_cyc - t0), 64'd3);
      check("t1_bus_we", {63'd0, hs_ctl[8]}, 64'd0);
      check("t1_bus_addr", hs_addr, 64'h8000_0000);
      drain("t1");

      // 2: both requesting; expected order M M M M I M M I
      exp_gnt_q.push_back(2'd2); exp_gnt_q.push_back(2'd2);
      exp_gnt_q.push_back(2'd2); exp_gnt_q.push_back(2'd2);
      exp_gnt_q.push_back(2'd1); exp_gnt_q.push_back(2'd2);
      exp_gnt_q.push_back(2'd2); exp_gnt_q.push_back(2'd1);
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               logic [63:0] a;
               a = 64'h8000_2000 + 64'(8 * i);
               mem_access(1'b0, a, '0, '0, bus_data(a), 1'b1);
            end
         end
         begin
            if_fetch(64'h8000_1000, bus_data(64'h8000_1000), 1'b1);
            if_fetch(64'h8000_1004, bus_data(64'h8000_1004), 1'b1);
         end
      join
      drain("t2");

      // 3: MEM write with 5 stalled ready cycles
      bus_stall = 5;
      exp_gnt_q.push_back(2'd2);
      t0 = cyc;
      mem_access(1'b1, 64'h8000_0100, 64'hDEAD_BEEF, 8'h0F, 64'd0, 1'b1);
      bus_stall = 0;
      check("t3_gnt_latency", 64'(mem_gnt_cyc - t0), 64'd6);
      check("t3_bus_addr", hs_addr, 64'h8000_0100);
      check("t3_bus_wdata", hs_wdata, 64'hDEAD_BEEF);
      check("t3_bus_we_wmask", {55'd0, hs_ctl}, {55'd0, 1'b1, 8'h0F});
      drain("t3");

      // 4a: flush during WAIT, response two cycles later
      bus_rlat = 3;
      exp_gnt_q.push_back(2'd1);
      if_fetch(64'h8000_0040, '0, 1'b0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      drain("t4a");
      // 4b: flush in the same cycle as bus_rvalid
      bus_rlat = 1;
      exp_gnt_q.push_back(2'd1);
      if_fetch(64'h8000_0080, '0, 1'b0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      drain("t4b");
      // 4c: next fetch completes normally
      exp_gnt_q.push_back(2'd1);
      if_fetch(64'h8000_0004, bus_data(64'h8000_0004), 1'b1);
      drain("t4c");
      // 4d: flush while MEM owns the bus has no effect
      bus_rlat = 3;
      exp_gnt_q.push_back(2'd2);
      mem_access(1'b0, 64'h8000_0300, '0, '0, bus_data(64'h8000_0300), 1'b1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      drain("t4d");
      // 4e: flush in IDLE (arbitration cycle) has no effect
      bus_rlat = 1;
      exp_gnt_q.push_back(2'd1);
      flush = 1'b1;
      fork
         begin
            @(posedge clk); #1;
            flush = 1'b0;
         end
      join_none
      if_fetch(64'h8000_0008, bus_data(64'h8000_0008), 1'b1);
      drain("t4e");

      // 5: reset during WAIT; late bus_rvalid must be ignored
      bus_rlat = 4;
      exp_gnt_q.push_back(2'd2);
      mem_access(1'b0, 64'h8000_0200, '0, '0, '0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check_outputs_zero("t5_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      bus_rlat = 1;
      exp_gnt_q.push_back(2'd2);
      mem_access(1'b0, 64'h8000_0208, '0, '0, bus_data(64'h8000_0208), 1'b1);
      drain("t5");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
